// File: rtl/lsr_pkg.sv
// Shared types, constants and helpers for the least-squares line blocks.
// q_t is the signed 16-bit fixed-point format used for gradients, intercepts and samples.
package lsr_pkg;

  typedef logic signed [15:0] q_t;

  localparam int FRAC_BITS_DEF = 8;
  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} lsr_eval_state_t;

  function automatic q_t sat16(input logic signed [34:0] v);
    if (v > 35'(SAT_MAX)) return q_t'(SAT_MAX);
    else if (v < 35'(SAT_MIN)) return q_t'(SAT_MIN);
    else return q_t'(v);
  endfunction

endpackage

// File: rtl/lsr_line_eval_if.sv
// Handshake and result bundle between the line evaluator and its neighbours.
// The slave modport is the evaluator's view; master is whoever drives the window.
interface lsr_line_eval_if import lsr_pkg::*; #(
  parameter int SSE_W = 40
) ();

  logic             start;
  q_t               m;
  q_t               b;
  logic [15:0]      shift;
  logic             busy;
  q_t               data_in;
  logic             data_valid;
  logic             data_ready;
  q_t               y_hat;
  q_t               residual;
  logic [16:0]      x_out;
  logic             res_valid;
  logic             res_ready;
  logic             last;
  logic             done;
  logic [SSE_W-1:0] sse;

  modport master (
    output start, m, b, shift, data_in, data_valid, res_ready,
    input  busy, data_ready, y_hat, residual, x_out, res_valid, last, done, sse
  );

  modport slave (
    input  start, m, b, shift, data_in, data_valid, res_ready,
    output busy, data_ready, y_hat, residual, x_out, res_valid, last, done, sse
  );

endinterface

// File: rtl/lsr_line_mac.sv
// Combinational line evaluator: y = m*x + b, rounded half-up to an integer
// and saturated to 16 bits. Reusable by any fitter working in the q_t format.
module lsr_line_mac import lsr_pkg::*; #(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  q_t          m,
  input  q_t          b,
  input  logic [16:0] x,
  output q_t          y_hat
);

  localparam logic signed [34:0] HALF = 35'sd1 <<< (FRAC_BITS - 1);

  logic signed [34:0] m_ext;
  logic signed [34:0] x_ext;
  logic signed [34:0] b_ext;
  logic signed [34:0] acc;
  logic signed [34:0] rounded;

  // One spare bit above the 34-bit product keeps the rounding add from overflowing.
  always_comb begin
    m_ext   = 35'(m);
    x_ext   = 35'($signed({1'b0, x}));
    b_ext   = 35'(b);
    acc     = m_ext * x_ext + b_ext;
    rounded = (acc + HALF) >>> FRAC_BITS;
    y_hat   = sat16(rounded);
  end

endmodule

// File: rtl/lsr_line_eval.sv
// Regenerates a fitted line over one window and scores the streamed samples
// against it, producing per-sample residuals and a saturating sum of squared error.
module lsr_line_eval import lsr_pkg::*; #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int SSE_W     = 40
) (
  input logic             clk,
  input logic             rst,
  lsr_line_eval_if.slave  io
);

  localparam int IDX_W = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_SIZE - 1);

  lsr_eval_state_t state, state_next;

  q_t                 m_r;
  q_t                 b_r;
  logic [15:0]        shift_r;
  logic [IDX_W-1:0]   idx;
  logic [16:0]        x;
  q_t                 y_line;
  logic signed [16:0] diff;
  q_t                 res_sat;
  logic signed [31:0] res_ext;
  logic signed [31:0] res_sq;
  logic [SSE_W:0]     sse_sum;
  logic [SSE_W-1:0]   sse_acc;
  logic               data_ready;
  logic               accept;
  q_t                 y_q;
  q_t                 res_q;
  logic [16:0]        x_q;
  logic               valid_q;
  logic               last_q;

  assign x = {1'b0, shift_r} + 17'(idx);

  lsr_line_mac #(.FRAC_BITS(FRAC_BITS)) u_mac (
    .m     (m_r),
    .b     (b_r),
    .x     (x),
    .y_hat (y_line)
  );

  // The extra sum bit is the saturation flag for the SSE accumulator.
  always_comb begin
    diff    = 17'(io.data_in) - 17'(y_line);
    res_sat = sat16(35'(diff));
    res_ext = 32'(res_sat);
    res_sq  = res_ext * res_ext;
    sse_sum = {1'b0, sse_acc} + {{(SSE_W-31){1'b0}}, res_sq};
  end

  always_comb begin
    state_next = state;
    data_ready = 1'b0;
    case (state)
      IDLE:  if (io.start) state_next = RUN;
      RUN: begin
        data_ready = !valid_q || io.res_ready;
        if (io.data_valid && data_ready && idx == IDX_LAST) state_next = FLUSH;
      end
      FLUSH: if (valid_q && io.res_ready) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign accept = data_ready && io.data_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m_r     <= '0;
      b_r     <= '0;
      shift_r <= '0;
      idx     <= '0;
      sse_acc <= '0;
      y_q     <= '0;
      res_q   <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && io.start) begin
        m_r     <= io.m;
        b_r     <= io.b;
        shift_r <= io.shift;
        idx     <= '0;
        sse_acc <= '0;
      end
      // A new accept overwrites the output register; otherwise a handshake empties it.
      if (accept) begin
        y_q     <= y_line;
        res_q   <= res_sat;
        x_q     <= x;
        last_q  <= (idx == IDX_LAST);
        valid_q <= 1'b1;
        idx     <= idx + IDX_W'(1);
        sse_acc <= sse_sum[SSE_W] ? '1 : sse_sum[SSE_W-1:0];
      end else if (valid_q && io.res_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign io.busy       = (state != IDLE);
  assign io.done       = (state == DONE);
  assign io.data_ready = data_ready;
  assign io.y_hat      = y_q;
  assign io.residual   = res_q;
  assign io.x_out      = x_q;
  assign io.res_valid  = valid_q;
  assign io.last       = last_q;
  assign io.sse        = sse_acc;

endmodule

// File: tb/tb_lsr_line_eval.sv
// Randomised scoreboard bench for lsr_line_eval with a DATA_SIZE=4 window;
// expectations come from an integer line model using floor division.
module tb_lsr_line_eval;

  localparam int  DS      = 4;
  localparam int  FRAC    = 8;
  localparam int  SSEW    = 40;
  localparam longint SSE_MAX = (64'sd1 <<< SSEW) - 1;

  typedef struct {
    longint y;
    longint res;
    longint x;
    longint last;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_count = 0;
  int   exp_done = 0;
  int   rr_mode = 0;
  int   stim [DS];
  int   mdl_m, mdl_b, mdl_shift;
  longint mdl_sse;
  exp_t sb [$];
  exp_t mon_e;

  lsr_line_eval_if #(.SSE_W(SSEW)) io ();

  lsr_line_eval #(.DATA_SIZE(DS), .FRAC_BITS(FRAC), .SSE_W(SSEW)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint floorDiv(longint a, longint d);
    longint q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint refLine(longint x);
    longint line_scaled = longint'(mdl_m) * x + longint'(mdl_b);
    return clamp16(floorDiv(line_scaled + (1 <<< (FRAC - 1)), 1 <<< FRAC));
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  // Downstream readiness: 0 always ready, 1 random stalls, 2 held off.
  initial begin
    io.res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       io.res_ready = 1'b1;
        1:       io.res_ready = ($urandom_range(0, 3) != 0);
        default: io.res_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (io.done) done_count++;
      if (io.res_valid && io.res_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_result: got x_out %0d, expected no result", io.x_out);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("y_hat", longint'(io.y_hat), mon_e.y);
          checkOutput("residual", longint'(io.residual), mon_e.res);
          checkOutput("x_out", longint'(io.x_out), mon_e.x);
          checkOutput("last", longint'(io.last), mon_e.last);
        end
      end
    end
  end

  // Starts a window and feeds n_feed samples from stim[]; entered and left at posedge+1.
  task automatic applyStimulus(input logic [15:0] mm, input logic [15:0] bb,
                               input logic [15:0] ss, input int n_feed, input bit gaps);
    exp_t e;
    int   cyc;
    int   g;
    io.start = 1'b1;
    io.m     = mm;
    io.b     = bb;
    io.shift = ss;
    @(posedge clk);
    #1;
    io.start  = 1'b0;
    mdl_m     = int'($signed(mm));
    mdl_b     = int'($signed(bb));
    mdl_shift = int'(ss);
    mdl_sse   = 0;
    for (int i = 0; i < n_feed; i++) begin
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      io.data_valid = 1'b1;
      io.data_in    = 16'(stim[i]);
      cyc = 0;
      forever begin
        @(negedge clk);
        if (io.data_ready) break;
        cyc++;
        if (cyc > 200) break;
        @(posedge clk);
        #1;
      end
      if (!io.data_ready) timeoutFail("data_accept");
      e.x    = longint'(mdl_shift + i);
      e.y    = refLine(e.x);
      e.res  = clamp16(longint'(stim[i]) - e.y);
      e.last = (i == DS - 1) ? 1 : 0;
      sb.push_back(e);
      mdl_sse = mdl_sse + e.res * e.res;
      if (mdl_sse > SSE_MAX) mdl_sse = SSE_MAX;
      @(posedge clk);
      #1;
      io.data_valid = 1'b0;
    end
  endtask

  task automatic waitDone();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!io.done && cyc < 300);
    if (!io.done) timeoutFail("done_wait");
    else begin
      exp_done++;
      checkOutput("sse", longint'(io.sse), mdl_sse);
      checkOutput("busy_at_done", longint'(io.busy), 1);
      checkOutput("results_drained", longint'(sb.size()), 0);
    end
    @(negedge clk);
    checkOutput("done_one_cycle", longint'(io.done), 0);
    checkOutput("busy_after_done", longint'(io.busy), 0);
    checkOutput("done_count", longint'(done_count), longint'(exp_done));
    @(posedge clk);
    #1;
  endtask

  task automatic holdCheck();
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(io.res_valid && sb.size() > 0) && cyc < 50);
    if (!(io.res_valid && sb.size() > 0)) timeoutFail("bp_first_result");
    else begin
      repeat (3) begin
        checkOutput("bp_data_ready", longint'(io.data_ready), 0);
        checkOutput("bp_y_hold", longint'(io.y_hat), sb[0].y);
        checkOutput("bp_x_hold", longint'(io.x_out), sb[0].x);
        @(negedge clk);
      end
    end
    rr_mode = 0;
  endtask

  task automatic setStim(input int d0, input int d1, input int d2, input int d3);
    stim[0] = d0;
    stim[1] = d1;
    stim[2] = d2;
    stim[3] = d3;
  endtask

  task automatic randStim();
    for (int i = 0; i < DS; i++) stim[i] = int'($signed(16'($urandom)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    io.start      = 1'b0;
    io.m          = '0;
    io.b          = '0;
    io.shift      = '0;
    io.data_in    = '0;
    io.data_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", longint'(io.busy), 0);
    checkOutput("rst_data_ready", longint'(io.data_ready), 0);
    checkOutput("rst_res_valid", longint'(io.res_valid), 0);
    checkOutput("rst_last", longint'(io.last), 0);
    checkOutput("rst_done", longint'(io.done), 0);
    checkOutput("rst_y_hat", longint'(io.y_hat), 0);
    checkOutput("rst_residual", longint'(io.residual), 0);
    checkOutput("rst_x_out", longint'(io.x_out), 0);
    checkOutput("rst_sse", longint'(io.sse), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] exact line, zero and nonzero residuals");
    setStim(1, 3, 5, 7);
    applyStimulus(16'h0200, 16'h0100, 16'd0, DS, 1'b0);
    waitDone();
    setStim(2, 3, 5, 10);
    applyStimulus(16'h0200, 16'h0100, 16'd0, DS, 1'b0);
    waitDone();
    checkOutput("sse_plan_value", longint'(io.sse), 10);

    $display("[TB] rounding ties, positive and negative gradient");
    setStim(0, 0, 0, 0);
    applyStimulus(16'h0080, 16'h0000, 16'd1, DS, 1'b0);
    waitDone();
    applyStimulus(16'hFF80, 16'h0000, 16'd1, DS, 1'b0);
    waitDone();

    $display("[TB] saturation of y_hat and residual");
    setStim(-32768, -32768, -32768, -32768);
    applyStimulus(16'h7FFF, 16'h0000, 16'd1000, DS, 1'b0);
    waitDone();

    $display("[TB] back-pressure hold");
    rr_mode = 2;
    @(posedge clk);
    #1;
    randStim();
    fork
      applyStimulus(16'h0123, 16'hFE00, 16'd50, DS, 1'b0);
      holdCheck();
    join
    waitDone();

    $display("[TB] start while busy is ignored");
    rr_mode = 1;
    randStim();
    fork
      applyStimulus(16'h0300, 16'h0A00, 16'd7, DS, 1'b1);
      begin
        repeat (3) @(posedge clk);
        #1;
        io.start = 1'b1;
        io.m     = 16'h7000;
        @(posedge clk);
        #1;
        io.start = 1'b0;
      end
    join
    waitDone();

    $display("[TB] randomised windows");
    for (int w = 0; w < 10; w++) begin
      randStim();
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), DS, 1'b1);
      waitDone();
    end

    $display("[TB] reset mid-window");
    rr_mode = 0;
    setStim(100, -100, 50, -50);
    applyStimulus(16'h0100, 16'h0000, 16'd5, 2, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput("abort_busy", longint'(io.busy), 0);
    checkOutput("abort_res_valid", longint'(io.res_valid), 0);
    checkOutput("abort_sse", longint'(io.sse), 0);
    checkOutput("abort_done", longint'(io.done), 0);
    repeat (4) @(negedge clk);
    checkOutput("abort_no_done", longint'(done_count), longint'(exp_done));
    @(posedge clk);
    #1;
    rr_mode = 1;
    randStim();
    applyStimulus(16'hFD40, 16'h3300, 16'd300, DS, 1'b1);
    waitDone();

    checkOutput("final_done_count", longint'(done_count), longint'(exp_done));
    checkOutput("final_sb_empty", longint'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
